// File: rtl/blft_param.sv
// Parametrised bilateral filter engine. Fetches a (2R+1)x(2R+1) clamped window around each
// pixel through an address/valid handshake, accumulates range- and distance-weighted sums and
// writes the rounded weighted average back in raster order.
module blft_param #(
  parameter int unsigned IMG_W = 256,
  parameter int unsigned IMG_H = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned R     = 2,
  parameter int unsigned WF    = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic [2*AW-1:0] in_addr,
  output logic            out_valid,
  output logic [2*AW-1:0] out_addr,
  output logic [DW-1:0]   out_data,
  output logic            finish
);

  localparam int unsigned K    = 2 * R + 1;
  localparam int unsigned TW   = $clog2(K + 1);
  localparam int unsigned WW   = WF + 1;
  localparam int unsigned DENW = WF + 1 + $clog2(K * K);
  localparam int unsigned NUMW = DENW + DW;
  localparam int unsigned REMW = NUMW + 1;
  localparam int unsigned QW   = DW + 1;
  localparam int unsigned CW   = $clog2(QW + 1);

  typedef enum logic [2:0] {
    StIdle,
    StCenter,
    StAccum,
    StDivide,
    StOutput,
    StDone
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   row_q, col_q;
  logic [TW-1:0]   dyi_q, dxi_q;
  logic [DW-1:0]   c_q;
  logic [1:0]      mode_q;
  logic [NUMW-1:0] num_q;
  logic [DENW-1:0] den_q;
  logic [REMW-1:0] rem_q, dsor_q;
  logic [QW-1:0]   q_q;
  logic [CW-1:0]   cnt_q;

  // Window tap address with coordinates clamped to the image (border replicate).
  function automatic logic [2*AW-1:0] tap_addr(input logic [AW-1:0] r, input logic [AW-1:0] c,
                                               input int dyi, input int dxi);
    int rr, cc;
    rr = int'(r) + dyi - int'(R);
    cc = int'(c) + dxi - int'(R);
    if (rr < 0) rr = 0;
    if (rr > int'(IMG_H) - 1) rr = int'(IMG_H) - 1;
    if (cc < 0) cc = 0;
    if (cc > int'(IMG_W) - 1) cc = int'(IMG_W) - 1;
    return {AW'(rr), AW'(cc)};
  endfunction

  logic [DW-1:0]   diff, sdiff;
  logic [2:0]      shamt;
  logic [WW-1:0]   rw, w;
  int              dy_abs, dx_abs, ndy, ndx;
  logic [NUMW-1:0] num_n;
  logic [DENW-1:0] den_n;
  logic            last_tap, last_pix, div_ge;

  // Tap weight, running sums including the current tap, and next tap position.
  always_comb begin
    diff   = (in_data > c_q) ? in_data - c_q : c_q - in_data;
    shamt  = {1'b0, mode_q} + 3'd2;
    sdiff  = diff >> shamt;
    rw     = (32'(sdiff) > WF) ? '0 : WW'((1 << WF) >> sdiff);
    dy_abs = (int'(dyi_q) >= int'(R)) ? int'(dyi_q) - int'(R) : int'(R) - int'(dyi_q);
    dx_abs = (int'(dxi_q) >= int'(R)) ? int'(dxi_q) - int'(R) : int'(R) - int'(dxi_q);
    w      = rw >> (dy_abs + dx_abs);
    num_n  = num_q + NUMW'(w) * NUMW'(in_data);
    den_n  = den_q + DENW'(w);
    if (dxi_q == TW'(K - 1)) begin
      ndx = 0;
      ndy = int'(dyi_q) + 1;
    end else begin
      ndx = int'(dxi_q) + 1;
      ndy = int'(dyi_q);
    end
    last_tap = (dxi_q == TW'(K - 1)) && (dyi_q == TW'(K - 1));
    last_pix = (row_q == AW'(IMG_H - 1)) && (col_q == AW'(IMG_W - 1));
    div_ge   = (rem_q >= dsor_q);
  end

  // Frame sequencer, window accumulation, restoring divider and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      row_q     <= '0;
      col_q     <= '0;
      dyi_q     <= '0;
      dxi_q     <= '0;
      c_q       <= '0;
      mode_q    <= '0;
      num_q     <= '0;
      den_q     <= '0;
      rem_q     <= '0;
      dsor_q    <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      in_addr   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      finish    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (state_q == StDone) finish <= 1'b1;
          if (start) begin
            finish  <= 1'b0;
            mode_q  <= mode;
            row_q   <= '0;
            col_q   <= '0;
            in_addr <= '0;
            state_q <= StCenter;
          end
        end
        StCenter: begin
          if (in_valid) begin
            c_q   <= in_data;
            num_q <= '0;
            den_q <= '0;
            dyi_q <= '0;
            dxi_q <= '0;
            if (mode_q == 2'd3) begin
              q_q     <= {1'b0, in_data};
              state_q <= StOutput;
            end else begin
              in_addr <= tap_addr(row_q, col_q, 0, 0);
              state_q <= StAccum;
            end
          end
        end
        StAccum: begin
          if (in_valid) begin
            num_q <= num_n;
            den_q <= den_n;
            if (last_tap) begin
              // Fold the rounding half-divisor into the dividend up front.
              rem_q   <= REMW'(num_n) + REMW'(den_n >> 1);
              dsor_q  <= REMW'(den_n) << DW;
              q_q     <= '0;
              cnt_q   <= '0;
              state_q <= StDivide;
            end else begin
              dyi_q   <= TW'(ndy);
              dxi_q   <= TW'(ndx);
              in_addr <= tap_addr(row_q, col_q, ndy, ndx);
            end
          end
        end
        StDivide: begin
          if (div_ge) rem_q <= rem_q - dsor_q;
          q_q    <= {q_q[QW-2:0], div_ge};
          dsor_q <= dsor_q >> 1;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(QW - 1)) state_q <= StOutput;
        end
        StOutput: begin
          out_valid <= 1'b1;
          out_data  <= q_q[QW-1] ? '1 : q_q[DW-1:0];
          out_addr  <= {row_q, col_q};
          if (last_pix) begin
            state_q <= StDone;
          end else begin
            if (col_q == AW'(IMG_W - 1)) begin
              col_q   <= '0;
              row_q   <= row_q + 1'b1;
              in_addr <= {row_q + 1'b1, {AW{1'b0}}};
            end else begin
              col_q   <= col_q + 1'b1;
              in_addr <= {row_q, col_q + 1'b1};
            end
            state_q <= StCenter;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/blft_param.md
# blft_param

Parametrised bilateral filter engine, the next generation of the team's fixed 256×256 filter. It fetches pixels from an external frame memory through an address/valid handshake and computes an edge-preserving weighted average over a (2R+1)×(2R+1) window around every pixel. Each result is written back in raster order with its address. New over the previous block: parametrised image size, window radius and pixel width; run-time range-sigma mode including bypass; clamped (replicate) border handling; and an explicit start/finish frame handshake.

## Interface
- IMG_W, 256, image width in pixels (≤ 2^AW)
- IMG_H, 256, image height in pixels (≤ 2^AW)
- AW, 8, bits per coordinate; addresses are {row, col}
- DW, 8, pixel width
- R, 2, window radius; K = 2R+1
- WF, 6, weight fraction bits; unit weight = 2^WF
- clk  input  1  clock
- rst  input  1  reset; one clock, asynchronous active-low reset
- start  input  1  one-cycle pulse that begins a frame; ignored while busy
- mode  input  2  range sigma select, sampled on start: 0 shift 2, 1 shift 3, 2 shift 4, 3 bypass
- in_valid  input  1  in_data is valid for the current in_addr
- in_data  input  DW  source pixel
- in_addr  output  2*AW  fetch address {row, col}
- out_valid  output  1  one-cycle pulse; out_data/out_addr valid
- out_addr  output  2*AW  {row, col} of the result
- out_data  output  DW  filtered pixel
- finish  output  1  high after the last pixel; held until the next start

## Operation
- States: IDLE → CENTER → ACCUM → DIVIDE → OUTPUT → (next pixel CENTER | DONE). DONE → CENTER on start.
- CENTER: fetch the pixel at (row, col) into c.
  - Bypass mode: go directly to OUTPUT with out_data = c.
- ACCUM: fetch K*K window pixels p in order dy = −R..R (outer) and dx = −R..R (inner).
  - Coordinates are clamped to [0, IMG_H−1] × [0, IMG_W−1], which replicates the border.
- Per fetched pixel:
  - d = |p − c|
  - s = d >> shift(mode)
  - rw = (s > WF) ? 0 : 2^WF >> s
  - w = rw >> (|dx| + |dy|)
  - num += w·p; den += w
- The centre tap always has w = 2^WF, so den ≥ 2^WF and never divides by zero.
- Widths:
  - w: WF+1 bits
  - den: WF+1+clog2(K*K) bits
  - num: den width + DW bits
  - No overflow is possible.
- DIVIDE: restoring divider computing q = (num + den/2) / den, one quotient bit per cycle for DW+1 cycles. q is saturated to 2^DW−1.
- OUTPUT: register out_data = q and out_addr = {row, col}; pulse out_valid. Advance col, wrapping to 0 and incrementing row at IMG_W−1.
- After pixel (IMG_H−1, IMG_W−1): enter DONE and assert finish.
- start in any state other than IDLE/DONE is ignored. start in DONE clears finish and restarts at (0,0).
- Reset values: in_addr 0, out_addr 0, out_data 0, out_valid 0, finish 0. State is IDLE and accumulators are 0. A reset mid-frame aborts with no further outputs.

## Timing
- in_addr is registered. When in_valid = 1, in_data is captured that edge and in_addr advances the next cycle.
- When in_valid = 0, the fetch stalls indefinitely with in_addr held.
- Per pixel with no stalls: 1 (CENTER) + K*K (ACCUM) + DW+1 (DIVIDE) + 1 (OUTPUT) cycles. For defaults this is 36 cycles.
- Per pixel in bypass mode: 2 cycles.
- out_valid is high for exactly one cycle per pixel. finish rises the cycle after the last out_valid.
- mode changes mid-frame have no effect.

## Test plan
- Reset: hold rst low, then release.
  - All outputs 0; no out_valid without start.
  - start then produces the first in_addr = {0,0}.
- Flat frame: IMG 8×8, R=2, all pixels 100, mode 0.
  - 64 out_valid pulses in raster order, all out_data = 100.
  - finish one cycle after the last pulse; 36 cycles per pixel.
- Step edge: 8×8, columns 0–3 = 0, columns 4–7 = 200, mode 0.
  - Cross-edge weights are 0, so every output equals its source exactly, including at the clamped borders.
- Weighted average: 3×3, R=1, all pixels 100 except (1,1) = 104, mode 2.
  - At (1,1): den = 256, num = 25856, out_data = 101.
  - Every other pixel outputs 100 or 101 as computed by the reference model.
- Bypass: mode 3, random 8×8 frame.
  - out_data equals the source at each address; 2 cycles per pixel.
  - A start pulse issued mid-frame is ignored.
- Stall and abort:
  - Drop in_valid for 10 cycles mid-ACCUM: in_addr is held and the result is unchanged.
  - Assert rst low mid-frame: out_valid and finish stay 0.
  - A new start then produces a complete, correct frame.
